// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct codes, ALUOp and mux-select encodings, state and class enums shared by the multi-cycle controller and datapath
package mips_ctrl_pkg;
    localparam logic [5:0] NONE_OP   = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam int ST_W = 4;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_EQ   = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_BGEZ = 3'b110;
    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_RS  = 1'b1;
    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;
    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;
    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;
    typedef enum logic [ST_W-1:0] {
        S_FETCH, S_DECODE, S_EXE, S_ALUWB, S_MEMADR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP
    } state_t;
    typedef enum logic [3:0] {
        C_ILL, C_ADDU, C_SUBU, C_OR, C_SLTIU, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_BGEZ, C_J, C_JAL, C_JR
    } cls_t;
    function automatic logic is_rtype(input cls_t c);
        return c == C_ADDU || c == C_SUBU || c == C_OR;
    endfunction
endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: combinational {opcode,funct} to instruction class
import mips_ctrl_pkg::*;
module instr_class_dec (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls
);
    // funct only matters inside the SPECIAL group
    always_comb begin
        cls = C_ILL;
        case (opcode)
            NONE_OP: cls = funct == FN_ADDU ? C_ADDU :
                           funct == FN_SUBU ? C_SUBU :
                           funct == FN_OR   ? C_OR   :
                           funct == FN_JR   ? C_JR   : C_ILL;
            OP_REGIMM: cls = C_BGEZ;
            OP_J:      cls = C_J;
            OP_JAL:    cls = C_JAL;
            OP_BEQ:    cls = C_BEQ;
            OP_SLTIU:  cls = C_SLTIU;
            OP_ORI:    cls = C_ORI;
            OP_LUI:    cls = C_LUI;
            OP_LW:     cls = C_LW;
            OP_SW:     cls = C_SW;
            default:   cls = C_ILL;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM driving PC/IR/GRF/DM enables, ALU selects and ALUOp
// CTRL_ILLEGAL_TRAP_EN: unknown instructions park in TRAP with illegal=1 until reset; otherwise they run as a nop
import mips_ctrl_pkg::*;
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [2:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] NPCOp,
    output logic       illegal
);
    state_t state, nxt;
    cls_t   cls, dec_cls;
    instr_class_dec u_dec (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls)
    );
    // state register; the class is captured once in DECODE so later states ignore IR changes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cls   <= C_ILL;
        end else begin
            state <= nxt;
            if (state == S_DECODE) cls <= dec_cls;
        end
    end
    // next state and Moore outputs; reset overrides every output so an aborted instruction writes nothing
    always_comb begin
        nxt      = S_FETCH;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_RT;
        ExtOp    = 1'b0;
        RegDst   = DST_RT;
        MemtoReg = WD_ALU;
        NPCOp    = NPC_PC4;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                ALUSrcB = SRCB_4;
                nxt     = S_DECODE;
            end
            S_DECODE: begin
                case (dec_cls)
                    C_ADDU, C_SUBU, C_OR, C_SLTIU, C_ORI, C_LUI: nxt = S_EXE;
                    C_LW, C_SW:                                 nxt = S_MEMADR;
                    C_BEQ, C_BGEZ:                              nxt = S_BRANCH;
                    C_J, C_JAL, C_JR:                           nxt = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                                    nxt = S_TRAP;
`else
                    default:                                    nxt = S_FETCH;
`endif
                endcase
            end
            S_EXE: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = is_rtype(cls) ? SRCB_RT : SRCB_IMM;
                ExtOp   = cls == C_SLTIU;
                ALUOp   = cls == C_SUBU  ? ALU_SUB  :
                          cls == C_OR || cls == C_ORI ? ALU_OR :
                          cls == C_LUI   ? ALU_LUI  :
                          cls == C_SLTIU ? ALU_SLTU : ALU_ADD;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                RegWr  = 1'b1;
                RegDst = is_rtype(cls) ? DST_RD : DST_RT;
                nxt    = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
                nxt     = cls == C_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: nxt = S_MEMWB;
            S_MEMWB: begin
                RegWr    = 1'b1;
                MemtoReg = WD_DM;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                MemWr = 1'b1;
                nxt   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS;
                ALUOp   = cls == C_BGEZ ? ALU_BGEZ : ALU_EQ;
                PCWr    = zero;
                NPCOp   = NPC_BR;
                nxt     = S_FETCH;
            end
            S_JUMP: begin
                PCWr     = 1'b1;
                NPCOp    = cls == C_JR ? NPC_RS : NPC_J;
                RegWr    = cls == C_JAL;
                RegDst   = cls == C_JAL ? DST_RA : DST_RT;
                MemtoReg = cls == C_JAL ? WD_PC : WD_ALU;
                nxt      = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
                nxt     = S_TRAP;
            end
`endif
            default: nxt = S_FETCH;
        endcase
        if (reset) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RegWr    = 1'b0;
            MemWr    = 1'b0;
            ALUOp    = ALU_ADD;
            ALUSrcA  = SRCA_PC;
            ALUSrcB  = SRCB_RT;
            ExtOp    = 1'b0;
            RegDst   = DST_RT;
            MemtoReg = WD_ALU;
            NPCOp    = NPC_PC4;
            illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-cycle checks of the mc_ctrl output vector against hand-computed values
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] opcode, funct;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrcA, ExtOp, illegal;
    logic [2:0] ALUOp;
    logic [1:0] ALUSrcB, RegDst, MemtoReg, NPCOp;
    logic [17:0] outv;
    int n_vec = 0;
    int n_err = 0;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .NPCOp(NPCOp), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign outv = {PCWr, IRWr, RegWr, MemWr, ALUOp, ALUSrcA, ALUSrcB, ExtOp, RegDst, MemtoReg, NPCOp, illegal};

    function automatic logic [17:0] v(input logic pc, ir, rw, mw, input logic [2:0] aop, input logic a,
                                      input logic [1:0] b, input logic ext, input logic [1:0] rd, m2r, npc, input logic ill);
        return {pc, ir, rw, mw, aop, a, b, ext, rd, m2r, npc, ill};
    endfunction

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [17:0] f_v, d_v, z_v;

    // cycles 1 and 2 are always FETCH/DECODE; the IR is scrambled after DECODE to prove the class is latched
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z, input int n,
                       input logic [17:0] e3, input logic [17:0] e4, input logic [17:0] e5);
        logic [17:0] e [3];
        e[0] = e3; e[1] = e4; e[2] = e5;
        opcode = op; funct = fn; zero = z;
        chk({tag, "_c1"}, outv, f_v);
        step;
        chk({tag, "_c2"}, outv, d_v);
        step;
        opcode = 6'h3f; funct = 6'h3f;
        for (int i = 3; i <= n; i++) begin
            chk($sformatf("%s_c%0d", tag, i), outv, e[i-3]);
            step;
        end
    endtask

    initial begin
        f_v = v(1,1,0,0,3'b000,0,2'd1,0,2'd0,2'd0,2'd0,0);
        d_v = 18'h0;
        z_v = 18'h0;
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        #1;
        chk("rst_pre", outv, z_v);
        for (int i = 0; i < 3; i++) begin
            step;
            chk($sformatf("rst_hold%0d", i), outv, z_v);
        end
        reset = 1'b0;
        #1;
        run("addu", 6'h00, 6'h21, 0, 4, v(0,0,0,0,3'b000,1,2'd0,0,2'd0,2'd0,2'd0,0), v(0,0,1,0,3'b000,0,2'd0,0,2'd1,2'd0,2'd0,0), z_v);
        run("subu", 6'h00, 6'h23, 0, 4, v(0,0,0,0,3'b001,1,2'd0,0,2'd0,2'd0,2'd0,0), v(0,0,1,0,3'b000,0,2'd0,0,2'd1,2'd0,2'd0,0), z_v);
        run("or",   6'h00, 6'h25, 0, 4, v(0,0,0,0,3'b011,1,2'd0,0,2'd0,2'd0,2'd0,0), v(0,0,1,0,3'b000,0,2'd0,0,2'd1,2'd0,2'd0,0), z_v);
        run("ori",  6'h0d, 6'h00, 0, 4, v(0,0,0,0,3'b011,1,2'd2,0,2'd0,2'd0,2'd0,0), v(0,0,1,0,3'b000,0,2'd0,0,2'd0,2'd0,2'd0,0), z_v);
        run("lui",  6'h0f, 6'h00, 0, 4, v(0,0,0,0,3'b100,1,2'd2,0,2'd0,2'd0,2'd0,0), v(0,0,1,0,3'b000,0,2'd0,0,2'd0,2'd0,2'd0,0), z_v);
        run("sltiu",6'h0b, 6'h00, 0, 4, v(0,0,0,0,3'b101,1,2'd2,1,2'd0,2'd0,2'd0,0), v(0,0,1,0,3'b000,0,2'd0,0,2'd0,2'd0,2'd0,0), z_v);
        run("lw",   6'h23, 6'h00, 0, 5, v(0,0,0,0,3'b000,1,2'd2,1,2'd0,2'd0,2'd0,0), z_v, v(0,0,1,0,3'b000,0,2'd0,0,2'd0,2'd1,2'd0,0));
        run("sw",   6'h2b, 6'h00, 0, 4, v(0,0,0,0,3'b000,1,2'd2,1,2'd0,2'd0,2'd0,0), v(0,0,0,1,3'b000,0,2'd0,0,2'd0,2'd0,2'd0,0), z_v);
        run("beq_t",6'h04, 6'h00, 1, 3, v(1,0,0,0,3'b010,1,2'd0,0,2'd0,2'd0,2'd1,0), z_v, z_v);
        run("beq_n",6'h04, 6'h00, 0, 3, v(0,0,0,0,3'b010,1,2'd0,0,2'd0,2'd0,2'd1,0), z_v, z_v);
        run("bgez", 6'h01, 6'h00, 1, 3, v(1,0,0,0,3'b110,1,2'd0,0,2'd0,2'd0,2'd1,0), z_v, z_v);
        run("j",    6'h02, 6'h00, 0, 3, v(1,0,0,0,3'b000,0,2'd0,0,2'd0,2'd0,2'd2,0), z_v, z_v);
        run("jal",  6'h03, 6'h00, 0, 3, v(1,0,1,0,3'b000,0,2'd0,0,2'd2,2'd2,2'd2,0), z_v, z_v);
        run("jr",   6'h00, 6'h08, 0, 3, v(1,0,0,0,3'b000,0,2'd0,0,2'd0,2'd0,2'd3,0), z_v, z_v);
        // sw aborted by reset in its MEMWR cycle
        run("swr",  6'h2b, 6'h00, 0, 3, v(0,0,0,0,3'b000,1,2'd2,1,2'd0,2'd0,2'd0,0), z_v, z_v);
        reset = 1'b1;
        #1;
        chk("swr_memwr_rst", outv, z_v);
        step;
        reset = 1'b0;
        #1;
        chk("swr_fetch", outv, f_v);
        run("bad", 6'h3f, 6'h00, 0, 2, z_v, z_v, z_v);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("trap%0d", i), outv, v(0,0,0,0,3'b000,0,2'd0,0,2'd0,2'd0,2'd0,1));
            step;
        end
        reset = 1'b1;
        #1;
        chk("trap_rst", outv, z_v);
        step;
        reset = 1'b0;
        #1;
`endif
        chk("end_fetch", outv, f_v);
        step;
        chk("end_decode", outv, d_v);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
